// File: rtl/vjtag_pkg.sv
// Shared definitions for the virtual JTAG register bridge: instruction codes,
// default IDCODE and the instruction-to-DR-length map.
package vjtag_pkg;

   localparam logic [3:0] IR_BYPASS = 4'h0;
   localparam logic [3:0] IR_IDCODE = 4'h1;
   localparam logic [3:0] IR_ADDR   = 4'h2;
   localparam logic [3:0] IR_WRITE  = 4'h3;
   localparam logic [3:0] IR_READ   = 4'h4;

   localparam logic [31:0] IDCODE_DEFAULT = 32'h5654_4A31;

   // Unassigned opcodes fall through to the 1-bit bypass length.
   function automatic int dr_length(input logic [3:0] ir, input int data_w, input int addr_w);
      case (ir)
         IR_IDCODE, IR_WRITE, IR_READ: return data_w;
         IR_ADDR:                      return addr_w;
         default:                      return 1;
      endcase
   endfunction

endpackage

// File: rtl/vjtag_reg_bridge_if.sv
// Register bus between the JTAG bridge (master) and the user register file (slave).
interface vjtag_reg_bridge_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [DATA_W-1:0] reg_rdata;

   modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
   modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/vjtag_dr_shifter.sv
// Variable-length LSB-first data register: parallel capture, serial shift with
// tdi entering at bit len-1 and everything above the active length forced to 0.
module vjtag_dr_shifter #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              tck,
   input  logic              rst,
   input  logic              cap_en,
   input  logic              shift_en,
   input  logic              tdi,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] cap_val,
   output logic [DATA_W-1:0] sr,
   output logic              tdo
);

   logic [DATA_W-1:0] sr_sh;
   logic [DATA_W-1:0] sr_nxt;

   assign sr_sh = sr >> 1;

   always_comb begin
      sr_nxt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i + 1 < int'(len))       sr_nxt[i] = sr_sh[i];
         else if (i + 1 == int'(len)) sr_nxt[i] = tdi;
      end
   end

   always_ff @(posedge tck) begin
      if (rst)           sr <= '0;
      else if (cap_en)   sr <= cap_val;
      else if (shift_en) sr <= sr_nxt;
   end

   assign tdo = sr[0];

endmodule

// File: rtl/vjtag_reg_bridge.sv
// Virtual JTAG hub consumer: decodes the virtual IR and turns completed DR scans
// into single-cycle register-bus strobes with address auto-increment.
module vjtag_reg_bridge
   import vjtag_pkg::*;
#(
   parameter int              DATA_W = 32,
   parameter int              ADDR_W = 8,
   parameter logic [DATA_W-1:0] IDCODE = DATA_W'(IDCODE_DEFAULT)
) (
   input  logic              tck,
   input  logic              rst,
   input  logic              tdi,
   output logic              tdo,
   input  logic [3:0]        ir_in,
   output logic [3:0]        ir_out,
   input  logic              virtual_state_cdr,
   input  logic              virtual_state_sdr,
   input  logic              virtual_state_udr,
   input  logic              virtual_state_uir,
   input  logic [3:0]        status,
   vjtag_reg_bridge_if.master bus
);

   localparam int LEN_W = $clog2(DATA_W + 1);

   logic [3:0]        ir_q;
   logic [LEN_W-1:0]  dr_len;
   logic [DATA_W-1:0] cap_val;
   logic [DATA_W-1:0] sr;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              re_q;
   logic              cap_en;
   logic              shift_en;
   logic              upd_en;

   // When the hub overlaps states, capture beats shift beats update.
   assign cap_en   = virtual_state_cdr;
   assign shift_en = virtual_state_sdr && !virtual_state_cdr;
   assign upd_en   = virtual_state_udr && !virtual_state_sdr && !virtual_state_cdr;

   assign dr_len = LEN_W'(dr_length(ir_q, DATA_W, ADDR_W));

   always_comb begin
      cap_val = '0;
      case (ir_q)
         IR_IDCODE: cap_val = IDCODE;
         IR_READ:   cap_val = bus.reg_rdata;
         IR_ADDR:   cap_val = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
         default:   cap_val = '0;
      endcase
   end

   vjtag_dr_shifter #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_dr_shifter (
      .tck      (tck),
      .rst      (rst),
      .cap_en   (cap_en),
      .shift_en (shift_en),
      .tdi      (tdi),
      .len      (dr_len),
      .cap_val  (cap_val),
      .sr       (sr),
      .tdo      (tdo)
   );

   // Strobe goes out the cycle after UDR with the old address; the increment
   // lands one cycle later so the register file sees a stable address.
   always_ff @(posedge tck) begin
      if (rst) begin
         ir_q    <= IR_BYPASS;
         ir_out  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         ir_out <= status;
         if (virtual_state_uir) ir_q <= ir_in;
         we_q <= upd_en && (ir_q == IR_WRITE);
         re_q <= upd_en && (ir_q == IR_READ);
         if (upd_en && (ir_q == IR_WRITE)) wdata_q <= sr;
         if (upd_en && (ir_q == IR_ADDR))  addr_q <= sr[ADDR_W-1:0];
         else if (we_q || re_q)            addr_q <= addr_q + ADDR_W'(1);
      end
   end

   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = we_q;
   assign bus.reg_re    = re_q;

endmodule

// File: doc/vjtag_reg_bridge.md
# vjtag_reg_bridge

Downstream consumer of the virtual JTAG hub instance: decodes the 4-bit virtual IR, implements per-instruction data registers shifted LSB-first, and converts completed DR scans into single-cycle register-bus read/write strobes in the `tck` domain. It sits between the VJTAG0 ports and the user register file. Host tools drive it through IR/DR scans, and it returns the IDCODE and status.

## Interface
Parameters:
- `DATA_W`, 32: register-bus data width and the WRITE/READ/IDCODE DR length.
- `ADDR_W`, 8: address register width and the ADDR DR length.
- `IDCODE`, 32'h5654_4A31: value captured by the IDCODE instruction.

Ports:
- `tck` in 1: sole clock, from the hub `tck`.
- `rst` in 1: reset, synchronous, active-high.
- `tdi` in 1: hub `tdi`.
- `tdo` out 1: to hub `tdo`.
- `ir_in` in 4: virtual IR from the hub.
- `ir_out` out 4: status captured into the IR on CIR.
- `virtual_state_cdr`, `virtual_state_sdr`, `virtual_state_udr`, `virtual_state_uir` in 1 each: hub virtual state decodes.
- `status` in 4: user status bits.
- `reg_addr` out ADDR_W: bus address.
- `reg_wdata` out DATA_W: bus write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read-acknowledge strobe.
- `reg_rdata` in DATA_W: combinational read data for `reg_addr`.

## Operation
- Instruction latch `ir_q` loads `ir_in` on the cycle `virtual_state_uir`=1. Decode:
  - 0x0 BYPASS: DR length 1.
  - 0x1 IDCODE: length DATA_W.
  - 0x2 ADDR: length ADDR_W.
  - 0x3 WRITE: length DATA_W.
  - 0x4 READ: length DATA_W.
  - 0x5–0xF decode as BYPASS.
- Shift register `sr` (DATA_W bits) operates per instruction length L:
  - On `sdr`: `sr <= sr >> 1` with `tdi` inserted at bit L-1. Bits at or above L are held at 0.
  - `tdo` = `sr[0]`, driven directly from the flop with no extra stage.
- Capture on `cdr`:
  - IDCODE: `sr` <= IDCODE.
  - READ: `sr` <= `reg_rdata`.
  - ADDR: `sr` <= zero-extended `reg_addr`.
  - WRITE and BYPASS: `sr` <= 0.
- Update on `udr`:
  - ADDR: `reg_addr` <= `sr[ADDR_W-1:0]`. No strobe.
  - WRITE: `reg_wdata` <= `sr`, `reg_we` pulses, then the address auto-increments.
  - READ: `reg_re` pulses, then the address auto-increments.
  - IDCODE and BYPASS: no effect.
- Address increment is modulo 2^ADDR_W, so 0xFF wraps to 0x00.
- `ir_out` is a register sampling `status` every cycle; the hub captures it on CIR.
- State priority if the hub asserts states together: `cdr` > `sdr` > `udr`. `uir` is independent.

## Timing
- Reset values:
  - `tdo`, `sr` = 0.
  - `ir_out` = 0.
  - `ir_q` = BYPASS.
  - `reg_addr`, `reg_wdata` = 0.
  - `reg_we`, `reg_re` = 0.
- Update sequence, with cycle k being the cycle `udr`=1:
  - k+1: `reg_we` (or `reg_re`) = 1, with `reg_addr` still holding the pre-increment address and `reg_wdata` valid.
  - k+2: strobe = 0 and `reg_addr` = addr+1.
- Strobes are exactly one cycle wide. Back-to-back UDRs at least 3 cycles apart yield one strobe each.
- `ir_out` has 1-cycle latency from `status`.
- `reg_rdata` is sampled on the `cdr` cycle itself and must be settled then.
- Reset asserted mid-scan discards `sr`, cancels any pending strobe or increment, and returns `ir_q` to BYPASS.
- Reset asserted on the `udr` cycle produces no strobe.

## Structure
- Package `vjtag_pkg` holds:
  - instruction code constants (BYPASS, IDCODE, ADDR, WRITE, READ)
  - the default IDCODE value
  - the function mapping an instruction to its DR length
- Sub-module `vjtag_dr_shifter`: the variable-length LSB-first shift register with capture load. Top level keeps `ir_q`, the update strobe pipeline and the address counter.

## Test plan
- Reset, then IR=0x1, CDR, 32 SDR cycles → `tdo` serialises 0x5654_4A31 LSB first. After reset, IR=0x0 DR scan → 1-cycle delay of `tdi`.
- IR=0x2 shift 0x10, UDR; IR=0x3 shift 0xDEADBEEF, UDR → `reg_we` high one cycle at k+1 with addr 0x10 and data 0xDEADBEEF; `reg_addr` = 0x11 at k+2.
- Addr 0xFF, WRITE update → strobe at 0xFF, `reg_addr` wraps to 0x00.
- IR=0x4, `reg_rdata`=0xCAFE0001 at CDR, 32 SDR → `tdo` stream 0xCAFE0001. UDR → `reg_re` pulse, address +1.
- Assert `rst` on the `udr` cycle of a WRITE → no `reg_we`, `reg_addr`=0, `ir_q`=BYPASS. IR=0x9 → behaves as BYPASS.
- `status`=0xA → `ir_out`=0xA one cycle later, and captured value 0xA is shifted out during the next IR scan.
